// File: rtl/data_mem_pkg.sv
// Shared encodings and lane/extension helpers for the byte-addressable
// data memory on the load/store path.
package data_mem_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic {
    CLEAR,
    RUN
  } state_e;

  function automatic logic is_fault(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    logic f;
    f = 1'b1;
    unique case (size)
      SIZE_B:  f = 1'b0;
      SIZE_H:  f = lo[0];
      SIZE_W:  f = (lo != 2'd0);
      default: f = 1'b1;
    endcase
    return f;
  endfunction

  function automatic logic [3:0] lane_mask(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    logic [3:0] m;
    m = 4'h0;
    unique case (size)
      SIZE_B:  m = 4'b0001 << lo;
      SIZE_H:  m = lo[1] ? 4'b1100 : 4'b0011;
      SIZE_W:  m = 4'b1111;
      default: m = 4'h0;
    endcase
    return m;
  endfunction

  // Replicate right-aligned store data across lanes; the mask picks one.
  function automatic logic [31:0] st_align(
    input logic [1:0]  size,
    input logic [31:0] wdata
  );
    logic [31:0] w;
    w = wdata;
    unique case (size)
      SIZE_B:  w = {4{wdata[7:0]}};
      SIZE_H:  w = {2{wdata[15:0]}};
      default: w = wdata;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] ld_extend(
    input logic [31:0] sh,
    input logic [1:0]  size,
    input logic        uns
  );
    logic [31:0] r;
    r = sh;
    unique case (size)
      SIZE_B:  r = {{24{~uns & sh[7]}}, sh[7:0]};
      SIZE_H:  r = {{16{~uns & sh[15]}}, sh[15:0]};
      default: r = sh;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/data_mem_if.sv
// Request/response handshake bundle between the memory stage
// and the data memory.
interface data_mem_if #(
  parameter int ADDR_W = 12
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_fault;

  modport master (
    output req_valid, req_we, req_addr,
    output req_size, req_unsigned, req_wdata,
    output rsp_ready,
    input  req_ready, rsp_valid,
    input  rsp_rdata, rsp_fault
  );

  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_size, req_unsigned, req_wdata,
    input  rsp_ready,
    output req_ready, rsp_valid,
    output rsp_rdata, rsp_fault
  );
endinterface

// File: rtl/data_mem_array.sv
// Word array with byte-enable writes and a registered read port.
// Contents are never reset.
module data_mem_array #(
  parameter int DEPTH = 1024,
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic             re,
  input  logic [IDX_W-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[addr];
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem.sv
// Data memory top: clear FSM, handshake, alignment checks and
// load extension around the byte-enable array.
module data_mem
  import data_mem_pkg::*;
#(
  parameter int ADDR_W         = 12,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input logic       clk,
  input logic       rst,
  data_mem_if.slave bus
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 1 << IDX_W;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             fault_q, fault_d;
  logic             ld_q, ld_d;
  logic [1:0]       lane_q, lane_d;
  logic [1:0]       size_q, size_d;
  logic             uns_q, uns_d;

  logic [1:0]       lo;
  logic [IDX_W-1:0] idx;
  logic             req_ready;
  logic             accept;
  logic             req_fault;

  logic             arr_we;
  logic             arr_re;
  logic [3:0]       arr_be;
  logic [IDX_W-1:0] arr_addr;
  logic [31:0]      arr_wdata;
  logic [31:0]      arr_rdata;
  logic [31:0]      shifted;

  assign lo        = bus.req_addr[1:0];
  assign idx       = bus.req_addr[ADDR_W-1:2];
  assign req_fault = is_fault(bus.req_size, lo);
  assign req_ready = !rst && (state_q == RUN) &&
                     (!rsp_valid_q || bus.rsp_ready);
  assign accept    = bus.req_valid && req_ready;

  always_comb begin
    arr_we    = 1'b0;
    arr_re    = 1'b0;
    arr_be    = 4'h0;
    arr_addr  = idx;
    arr_wdata = '0;
    if (state_q == CLEAR) begin
      arr_we   = 1'b1;
      arr_be   = 4'hF;
      arr_addr = clr_idx_q;
    end else if (accept && !req_fault) begin
      if (bus.req_we) begin
        arr_we    = 1'b1;
        arr_be    = lane_mask(bus.req_size, lo);
        arr_wdata = st_align(bus.req_size, bus.req_wdata);
      end else begin
        arr_re = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_idx_d   = clr_idx_q;
    rsp_valid_d = rsp_valid_q;
    fault_d     = fault_q;
    ld_d        = ld_q;
    lane_d      = lane_q;
    size_d      = size_q;
    uns_d       = uns_q;
    if (state_q == CLEAR) begin
      clr_idx_d = clr_idx_q + 1'b1;
      if (clr_idx_q == IDX_W'(DEPTH - 1)) state_d = RUN;
    end
    if (accept) begin
      rsp_valid_d = 1'b1;
      fault_d     = req_fault;
      ld_d        = !bus.req_we && !req_fault;
      lane_d      = lo;
      size_d      = bus.req_size;
      uns_d       = bus.req_unsigned;
    end else if (bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR_ON_RESET ? CLEAR : RUN;
      clr_idx_q   <= '0;
      rsp_valid_q <= 1'b0;
      fault_q     <= 1'b0;
      ld_q        <= 1'b0;
      lane_q      <= 2'd0;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      rsp_valid_q <= rsp_valid_d;
      fault_q     <= fault_d;
      ld_q        <= ld_d;
      lane_q      <= lane_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
    end
  end

  data_mem_array #(
    .DEPTH(DEPTH),
    .IDX_W(IDX_W)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .be   (arr_be),
    .re   (arr_re),
    .addr (arr_addr),
    .wdata(arr_wdata),
    .rdata(arr_rdata)
  );

  // Read register holds until the next accepted load, so the
  // extended output stays stable under backpressure.
  assign shifted       = arr_rdata >> {lane_q, 3'b000};
  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_fault = fault_q;
  assign bus.rsp_rdata = ld_q ? ld_extend(shifted, size_q, uns_q)
                              : 32'h0;

endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem: vector table plus clear, backpressure,
// back-to-back and reset-restart sequences.
module tb_data_mem;

  logic clk;
  logic rst;
  int   n_run;
  int   n_fail;

  data_mem_if #(.ADDR_W(6)) bus ();

  data_mem #(
    .ADDR_W(6),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [5:0]  addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_fault;
  } vec_t;

  vec_t vecs [19];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [5:0] addr,
                        input logic [1:0] size, input logic uns,
                        input logic [31:0] wdata,
                        output logic [31:0] rdata,
                        output logic fault);
    int n;
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_addr     = addr;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_wdata    = wdata;
    n = 0;
    while (!bus.req_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) check("req_timeout", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    rdata = bus.rsp_rdata;
    fault = bus.rsp_fault;
  endtask

  task automatic count_clear(input string name);
    int n;
    n = 0;
    while (!bus.req_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check(name, n, 32'd16);
  endtask

  logic [31:0] rd;
  logic        fl;

  initial begin
    n_run  = 0;
    n_fail = 0;
    //           we    addr   sz    uns   wdata          rdata          flt
    vecs[0]  = '{1'b0, 6'h00, 2'd2, 1'b0, 32'h0,         32'h00000000, 1'b0};
    vecs[1]  = '{1'b0, 6'h3C, 2'd2, 1'b0, 32'h0,         32'h00000000, 1'b0};
    vecs[2]  = '{1'b1, 6'h10, 2'd2, 1'b0, 32'h11223344,  32'h00000000, 1'b0};
    vecs[3]  = '{1'b1, 6'h11, 2'd0, 1'b0, 32'h000000AA,  32'h00000000, 1'b0};
    vecs[4]  = '{1'b1, 6'h12, 2'd1, 1'b0, 32'h0000BEEF,  32'h00000000, 1'b0};
    vecs[5]  = '{1'b0, 6'h10, 2'd2, 1'b0, 32'h0,         32'hBEEFAA44, 1'b0};
    vecs[6]  = '{1'b0, 6'h11, 2'd0, 1'b0, 32'h0,         32'hFFFFFFAA, 1'b0};
    vecs[7]  = '{1'b0, 6'h11, 2'd0, 1'b1, 32'h0,         32'h000000AA, 1'b0};
    vecs[8]  = '{1'b0, 6'h12, 2'd1, 1'b0, 32'h0,         32'hFFFFBEEF, 1'b0};
    vecs[9]  = '{1'b0, 6'h12, 2'd1, 1'b1, 32'h0,         32'h0000BEEF, 1'b0};
    vecs[10] = '{1'b0, 6'h10, 2'd0, 1'b0, 32'h0,         32'h00000044, 1'b0};
    vecs[11] = '{1'b0, 6'h10, 2'd1, 1'b0, 32'h0,         32'hFFFFAA44, 1'b0};
    vecs[12] = '{1'b0, 6'h13, 2'd0, 1'b1, 32'h0,         32'h000000BE, 1'b0};
    vecs[13] = '{1'b1, 6'h14, 2'd2, 1'b0, 32'hCAFEF00D,  32'h00000000, 1'b0};
    vecs[14] = '{1'b0, 6'h13, 2'd1, 1'b0, 32'h0,         32'h00000000, 1'b1};
    vecs[15] = '{1'b1, 6'h16, 2'd2, 1'b0, 32'h12345678,  32'h00000000, 1'b1};
    vecs[16] = '{1'b0, 6'h00, 2'd3, 1'b0, 32'h0,         32'h00000000, 1'b1};
    vecs[17] = '{1'b1, 6'h15, 2'd0, 1'b0, 32'h00000077,  32'h00000000, 1'b0};
    vecs[18] = '{1'b0, 6'h14, 2'd2, 1'b0, 32'h0,         32'hCAFE770D, 1'b0};

    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_addr     = '0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_wdata    = '0;
    bus.rsp_ready    = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst_rsp_fault", 32'(bus.rsp_fault), 32'd0);
    rst = 1'b0;
    count_clear("clear_cycles");

    for (int i = 0; i < 19; i++) begin
      do_req(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].uns,
             vecs[i].wdata, rd, fl);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_fault", i), 32'(fl),
            32'(vecs[i].exp_fault));
    end

    // Backpressure: pending load response, next request waiting.
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    do_req(1'b0, 6'h10, 2'd2, 1'b0, 32'h0, rd, fl);
    check("bp_first", rd, 32'hBEEFAA44);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 6'h14;
    bus.req_size  = 2'd2;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check($sformatf("bp_ready%0d", c), 32'(bus.req_ready), 32'd0);
      check($sformatf("bp_rdata%0d", c), bus.rsp_rdata, 32'hBEEFAA44);
      check($sformatf("bp_valid%0d", c), 32'(bus.rsp_valid), 32'd1);
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("bp_next_valid", 32'(bus.rsp_valid), 32'd1);
    check("bp_next_rdata", bus.rsp_rdata, 32'hCAFE770D);

    // Back-to-back store then load of the same word.
    @(posedge clk); #1;
    check("idle_valid", 32'(bus.rsp_valid), 32'd0);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 6'h20;
    bus.req_size  = 2'd2;
    bus.req_wdata = 32'hDEADBEEF;
    #1;
    check("b2b_ready0", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    check("b2b_valid0", 32'(bus.rsp_valid), 32'd1);
    check("b2b_rdata0", bus.rsp_rdata, 32'h0);
    check("b2b_ready1", 32'(bus.req_ready), 32'd1);
    bus.req_we = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("b2b_valid1", 32'(bus.rsp_valid), 32'd1);
    check("b2b_rdata1", bus.rsp_rdata, 32'hDEADBEEF);
    @(posedge clk); #1;
    check("b2b_drain", 32'(bus.rsp_valid), 32'd0);

    // Reset mid-clear: seven clear writes, then reset again.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("mid_clear_ready", 32'(bus.req_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    count_clear("restart_cycles");
    do_req(1'b0, 6'h10, 2'd2, 1'b0, 32'h0, rd, fl);
    check("cleared_10", rd, 32'h0);
    do_req(1'b0, 6'h20, 2'd2, 1'b0, 32'h0, rd, fl);
    check("cleared_20", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem.md
# data_mem

Parametrised, byte-addressable data memory for the RISC-V core's load/store path. It replaces the plain word-array RAM with:
- byte, half-word and word accesses, with sign or zero extension on loads;
- misaligned-access fault reporting;
- a valid/ready request/response handshake with response backpressure;
- a hardware clear sequence that zeroes the array after reset.

It sits between the core's memory stage and the on-chip storage.

## Interface
- ADDR_W, 12, byte-address width; array depth is DEPTH = 2**(ADDR_W-2) 32-bit words (default 1024).
- CLEAR_ON_RESET, 1, when 1 the array is zeroed after reset before requests are accepted; when 0 the block is ready immediately.

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes the response
- rsp_rdata  out  32  extended load data; 0 for stores and faults
- rsp_fault  out  1  request was misaligned or illegal size

## Operation
- States: CLEAR, RUN.
  - rst → CLEAR when CLEAR_ON_RESET = 1, otherwise RUN.
  - rst also clears the clear counter clr_idx to 0, rsp_valid to 0, rsp_rdata to 0 and rsp_fault to 0.
- CLEAR: each cycle writes 0 to word clr_idx, then increments clr_idx. After writing word DEPTH-1, go to RUN.
  - The clear takes exactly DEPTH cycles.
  - rst asserted mid-clear restarts the sequence at 0.
- req_ready = (state == RUN) && (!rsp_valid || rsp_ready). A request is accepted on a cycle with req_valid && req_ready.
- Every accepted request produces exactly one response, in order.
- Fault conditions:
  - req_size == 3;
  - half access with addr[0] = 1;
  - word access with addr[1:0] != 0.
  - A faulting store writes nothing. A faulting load returns rdata 0. In both cases rsp_fault = 1.
- Store, word index addr[ADDR_W-1:2]:
  - byte writes lane addr[1:0] with wdata[7:0];
  - half writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0];
  - word writes all four lanes.
  - Other lanes are unchanged. The response carries rdata 0 and fault 0.
- Load:
  - Read word index addr[ADDR_W-1:2] and shift right by 8*addr[1:0].
  - Take the low 8, 16 or 32 bits.
  - Extend to 32 bits per req_unsigned; word loads ignore req_unsigned.
- Backpressure: while rsp_valid && !rsp_ready, rsp_rdata and rsp_fault hold stable and no request is accepted.
- Response register update:
  - on accept: rsp_valid ← 1;
  - else if rsp_ready: rsp_valid ← 0.

## Timing
- Reset values: req_ready 0 during rst; rsp_valid 0, rsp_rdata 0, rsp_fault 0.
- After rst deasserts, req_ready rises:
  - after DEPTH cycles when CLEAR_ON_RESET = 1;
  - on the next cycle when CLEAR_ON_RESET = 0.
- Latency: response valid on the cycle after acceptance (1 cycle).
- Throughput: one request per cycle while rsp_ready is held high.
- Store data commits at the acceptance edge. A load accepted on the following cycle returns the new data; there is no stale read.
- A request and a response handoff on the same edge (rsp_ready = 1, new accept) is legal: the response register reloads with no bubble.

## Structure
- Package data_mem_pkg holds:
  - size encodings SIZE_B = 2'd0, SIZE_H = 2'd1, SIZE_W = 2'd2;
  - the state enum {CLEAR, RUN};
  - the functions computing the byte-lane mask and the fault flag from size and addr[1:0].
- Sub-module data_mem_array: DEPTH × 32 synchronous-write array with a 4-bit byte-enable, a registered read port, and no reset of contents.
  - The top level owns the FSM, the handshake, alignment and extension.

## Test plan
- Clear: CLEAR_ON_RESET = 1, ADDR_W = 6 → req_ready rises 16 cycles after rst falls. Word loads at 0x00 and 0x3C return 0x00000000.
- Byte/half stores: SW 0x11223344 @0x10; SB 0xAA @0x11; SH 0xBEEF @0x12.
  - LW @0x10 → 0xBEEFAA44.
  - LB @0x11 → 0xFFFFFFAA.
  - LBU @0x11 → 0x000000AA.
  - LH @0x12 → 0xFFFFBEEF.
- Faults: LH @0x13, SW @0x16, size = 3 @0x00 → each response has rsp_fault = 1 and rdata 0. A following LW @0x14 shows the word unchanged.
- Backpressure: hold rsp_ready = 0 with a load response pending → req_ready = 0 and rsp_rdata stable for 5 cycles. Release → the next request is accepted the same cycle.
- Back-to-back: SW 0xDEADBEEF @0x20 then LW @0x20 on consecutive cycles with rsp_ready = 1 → second response rdata 0xDEADBEEF, one response per cycle.
- Reset mid-clear: assert rst at clr_idx = 7 → the clear restarts and takes the full DEPTH cycles again.
